// File: rtl/ov2640_capture.sv
// ----------------------------------------------------------------------------
// ov2640_capture
// Samples the OV2640 DVP bus in the system clock domain once camera register
// initialisation has completed. Byte pairs are packed into RGB565 pixels and
// tagged with x/y coordinates and frame start/done markers. The frame-buffer
// writer downstream has no backpressure.
//
// Ports:
//   clk_i         system clock, at least 4x the camera pclk
//   rst_i         synchronous reset, active-low
//   cfg_done_i    level, high once camera register init has finished
//   cam_pclk_i    camera pixel clock (asynchronous, oversampled)
//   cam_vsync_i   camera vsync, active-high blanking pulse
//   cam_href_i    camera line valid
//   cam_data_i    camera data byte
//   pix_valid_o   one-cycle strobe, pixel fields valid
//   pix_data_o    RGB565 pixel
//   pix_x_o       column of pix_data_o
//   pix_y_o       row of pix_data_o
//   frame_start_o one-cycle pulse with the first pixel of a frame
//   frame_done_o  one-cycle pulse at vsync rise after an active frame
//   frame_err_o   sticky size / odd byte count error
//
// Optional build macro:
//   OV2640_CAPTURE_DECIMATE_EN  2x downscale: only even x / even y pixels are
//                               emitted, with coordinates halved.
// ----------------------------------------------------------------------------
module ov2640_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_done_i,
  input  logic          cam_pclk_i,
  input  logic          cam_vsync_i,
  input  logic          cam_href_i,
  input  logic [7:0]    cam_data_i,
  output logic          pix_valid_o,
  output logic [15:0]   pix_data_o,
  output logic [XW-1:0] pix_x_o,
  output logic [YW-1:0] pix_y_o,
  output logic          frame_start_o,
  output logic          frame_done_o,
  output logic          frame_err_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_VS  = 2'd1;
  localparam logic [1:0] WAIT_ACT = 2'd2;
  localparam logic [1:0] ACTIVE   = 2'd3;

  localparam logic [XW-1:0] X_LIMIT = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LIMIT = YW'(V_ACTIVE);
  localparam logic [XW-1:0] X_MAX   = '1;
  localparam logic [YW-1:0] Y_MAX   = '1;

  // Synchroniser and edge-detect stage registers
  logic       pclkS1_q, pclkS2_q, pclkS3_q;
  logic       vsyncS1_q, vsyncS2_q;
  logic       hrefS1_q, hrefS2_q;
  logic [7:0] dataS1_q, dataS2_q;
  logic       evRise_q, evVsync_q, evHref_q;
  logic [7:0] evData_q;

  // Capture state
  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic          first_q, first_d;
  logic          vsPrev_q, vsPrev_d;
  logic          hrefPrev_q, hrefPrev_d;
  logic          pixValid_q, pixValid_d;
  logic [15:0]   pixData_q, pixData_d;
  logic [XW-1:0] pixX_q, pixX_d;
  logic [YW-1:0] pixY_q, pixY_d;
  logic          frameStart_q, frameStart_d;
  logic          frameDone_q, frameDone_d;
  logic          frameErr_q, frameErr_d;

  logic          vsRise, vsFall, hrefFall, emitOk;
  logic [YW-1:0] lineY;

  // Two-flop synchronisers; data takes the same two stages so it lines up
  // with href/vsync. The event stage registers the detected pclk rise along
  // with the camera signals sampled at that same point.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pclkS1_q  <= 1'b0;  pclkS2_q  <= 1'b0;  pclkS3_q <= 1'b0;
      vsyncS1_q <= 1'b0;  vsyncS2_q <= 1'b0;
      hrefS1_q  <= 1'b0;  hrefS2_q  <= 1'b0;
      dataS1_q  <= 8'h00; dataS2_q  <= 8'h00;
      evRise_q  <= 1'b0;  evVsync_q <= 1'b0;  evHref_q <= 1'b0;
      evData_q  <= 8'h00;
    end else begin
      pclkS1_q  <= cam_pclk_i;  pclkS2_q  <= pclkS1_q;  pclkS3_q <= pclkS2_q;
      vsyncS1_q <= cam_vsync_i; vsyncS2_q <= vsyncS1_q;
      hrefS1_q  <= cam_href_i;  hrefS2_q  <= hrefS1_q;
      dataS1_q  <= cam_data_i;  dataS2_q  <= dataS1_q;
      evRise_q  <= pclkS2_q & ~pclkS3_q;
      evVsync_q <= vsyncS2_q;
      evHref_q  <= hrefS2_q;
      evData_q  <= dataS2_q;
    end
  end

  // vsync/href edges are judged only between consecutive pclk rises.
  assign vsRise   = evRise_q &  evVsync_q & ~vsPrev_q;
  assign vsFall   = evRise_q & ~evVsync_q &  vsPrev_q;
  assign hrefFall = evRise_q & ~evHref_q  &  hrefPrev_q;

`ifdef OV2640_CAPTURE_DECIMATE_EN
  assign emitOk = ~x_q[0] & ~y_q[0];
`else
  assign emitOk = 1'b1;
`endif

  // Next-state logic. Within ACTIVE a line end is closed before a vsync
  // rise in the same event so the frame size check sees the final row count.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    first_d      = first_q;
    vsPrev_d     = vsPrev_q;
    hrefPrev_d   = hrefPrev_q;
    pixValid_d   = 1'b0;
    pixData_d    = pixData_q;
    pixX_d       = pixX_q;
    pixY_d       = pixY_q;
    frameStart_d = 1'b0;
    frameDone_d  = 1'b0;
    frameErr_d   = frameErr_q;
    lineY        = y_q;

    if (evRise_q) begin
      vsPrev_d   = evVsync_q;
      hrefPrev_d = evHref_q;
    end

    case (state_q)
      IDLE: begin
        if (cfg_done_i) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (evRise_q && evVsync_q) begin
          state_d    = WAIT_ACT;
          frameErr_d = 1'b0;
        end
      end
      WAIT_ACT: begin
        if (vsFall) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          first_d = 1'b1;
        end
      end
      default: begin
        if (hrefFall) begin
          if (phase_q || (x_q != X_LIMIT)) frameErr_d = 1'b1;
          if (y_q != Y_MAX) lineY = y_q + 1'b1;
          y_d     = lineY;
          x_d     = '0;
          phase_d = 1'b0;
        end
        if (vsRise) begin
          frameDone_d = 1'b1;
          if (lineY != Y_LIMIT) frameErr_d = 1'b1;
          state_d = WAIT_ACT;
        end else if (evRise_q && evHref_q) begin
          if (!phase_q) begin
            hi_d    = evData_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((x_q < X_LIMIT) && (y_q < Y_LIMIT)) begin
              if (emitOk) begin
                pixValid_d   = 1'b1;
                pixData_d    = {hi_q, evData_q};
`ifdef OV2640_CAPTURE_DECIMATE_EN
                pixX_d       = x_q >> 1;
                pixY_d       = y_q >> 1;
`else
                pixX_d       = x_q;
                pixY_d       = y_q;
`endif
                frameStart_d = first_q;
                first_d      = 1'b0;
              end
            end else begin
              frameErr_d = 1'b1;
            end
            if (x_q != X_MAX) x_d = x_q + 1'b1;
          end
        end
      end
    endcase

    // Losing configuration abandons whatever was in progress silently.
    if (!cfg_done_i) begin
      state_d      = IDLE;
      pixValid_d   = 1'b0;
      frameStart_d = 1'b0;
      frameDone_d  = 1'b0;
      frameErr_d   = frameErr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      hi_q         <= 8'h00;
      first_q      <= 1'b0;
      vsPrev_q     <= 1'b0;
      hrefPrev_q   <= 1'b0;
      pixValid_q   <= 1'b0;
      pixData_q    <= 16'h0000;
      pixX_q       <= '0;
      pixY_q       <= '0;
      frameStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      first_q      <= first_d;
      vsPrev_q     <= vsPrev_d;
      hrefPrev_q   <= hrefPrev_d;
      pixValid_q   <= pixValid_d;
      pixData_q    <= pixData_d;
      pixX_q       <= pixX_d;
      pixY_q       <= pixY_d;
      frameStart_q <= frameStart_d;
      frameDone_q  <= frameDone_d;
      frameErr_q   <= frameErr_d;
    end
  end

  assign pix_valid_o   = pixValid_q;
  assign pix_data_o    = pixData_q;
  assign pix_x_o       = pixX_q;
  assign pix_y_o       = pixY_q;
  assign frame_start_o = frameStart_q;
  assign frame_done_o  = frameDone_q;
  assign frame_err_o   = frameErr_q;

endmodule

// File: tb/tb_ov2640_capture.sv
// ----------------------------------------------------------------------------
// tb_ov2640_capture
// Drives ov2640_capture (H_ACTIVE=4, V_ACTIVE=2) with whole DVP frames and
// lines. A line-level model predicts every emitted pixel, the frame_done
// count and the sticky error flag; a compare process checks each pix_valid.
// ----------------------------------------------------------------------------
module tb_ov2640_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = 10;
  localparam int YW = 9;

`ifdef OV2640_CAPTURE_DECIMATE_EN
  localparam bit DECIM     = 1'b1;
  localparam int EXP_CNT   = 2;
  localparam int EXP_LASTX = 1;
  localparam int EXP_LASTY = 0;
`else
  localparam bit DECIM     = 1'b0;
  localparam int EXP_CNT   = 8;
  localparam int EXP_LASTX = 3;
  localparam int EXP_LASTY = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfgDone = 1'b0;
  logic          camPclk = 1'b0;
  logic          camVsync = 1'b0;
  logic          camHref = 1'b0;
  logic [7:0]    camData = 8'h00;
  logic          pixValid;
  logic [15:0]   pixData;
  logic [XW-1:0] pixX;
  logic [YW-1:0] pixY;
  logic          frameStart, frameDone, frameErr;

  always #5 clk = ~clk;

  ov2640_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_done_i(cfgDone),
    .cam_pclk_i(camPclk), .cam_vsync_i(camVsync), .cam_href_i(camHref),
    .cam_data_i(camData),
    .pix_valid_o(pixValid), .pix_data_o(pixData), .pix_x_o(pixX),
    .pix_y_o(pixY), .frame_start_o(frameStart), .frame_done_o(frameDone),
    .frame_err_o(frameErr)
  );

  typedef struct {
    logic [15:0]   d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fs;
  } pix_t;

  pix_t expQ[$];

  // Model state: whether capture is enabled, whether a frame is open, etc.
  bit   armed, inFrame, firstPix, modelErr, clearPending;
  int   lineCnt, doneExp, doneSeen, pixSeen;
  int   checks, errors;
  logic [15:0]   firstData;
  logic [XW-1:0] firstX, lastX;
  logic [YW-1:0] firstY, lastY;
  logic          firstFs;
  logic [7:0]    seqByte = 8'h12;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Every emitted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    pix_t e;
    if (rst) begin
      if (frameDone) doneSeen++;
      if (frameStart && !pixValid) checkOutput("fs_without_valid", 32'd1, 32'd0);
      if (pixValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pixel", {16'h0, pixData}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("pix_data", {16'h0, pixData}, {16'h0, e.d});
          checkOutput("pix_x", 32'(pixX), 32'(e.x));
          checkOutput("pix_y", 32'(pixY), 32'(e.y));
          checkOutput("frame_start", 32'(frameStart), 32'(e.fs));
        end
        if (pixSeen == 0) begin
          firstData = pixData; firstX = pixX; firstY = pixY; firstFs = frameStart;
        end
        lastX = pixX; lastY = pixY;
        pixSeen++;
      end
    end
  end

  // One camera pclk period (4 clk low, 4 clk high); signals change while low.
  task automatic applyStimulus(input logic h, input logic v, input logic [7:0] d);
    camPclk = 1'b0; camHref = h; camVsync = v; camData = d;
    repeat (4) @(negedge clk);
    camPclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic sendVsync();
    if (inFrame) begin
      doneExp++;
      if (lineCnt != V) modelErr = 1'b1;
    end
    if (armed) begin
      if (clearPending) begin modelErr = 1'b0; clearPending = 1'b0; end
      inFrame = 1'b1; lineCnt = 0; firstPix = 1'b1;
    end
    repeat (2) applyStimulus(1'b0, 1'b1, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendLine(input int n, input bit useSeq);
    logic [7:0] b [0:15];
    pix_t p;
    for (int i = 0; i < n; i++) begin
      if (useSeq) begin b[i] = seqByte; seqByte = seqByte + 8'h22; end
      else b[i] = 8'($urandom);
    end
    if (inFrame) begin
      for (int k = 0; k < n / 2; k++) begin
        if (k < H && lineCnt < V) begin
          if (!DECIM || ((k % 2 == 0) && (lineCnt % 2 == 0))) begin
            p.d  = {b[2*k], b[2*k+1]};
            p.x  = DECIM ? XW'(k / 2) : XW'(k);
            p.y  = DECIM ? YW'(lineCnt / 2) : YW'(lineCnt);
            p.fs = firstPix;
            firstPix = 1'b0;
            expQ.push_back(p);
          end
        end else begin
          modelErr = 1'b1;
        end
      end
      if ((n % 2) != 0 || (n / 2) != H) modelErr = 1'b1;
      lineCnt++;
    end
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, b[i]);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic dropCfg();
    cfgDone = 1'b0;
    armed = 1'b0; inFrame = 1'b0; clearPending = 1'b1;
    repeat (3) @(negedge clk);
    cfgDone = 1'b1; armed = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    repeat (4) @(negedge clk);
    checkOutput({tag, "_done_cnt"}, 32'(doneSeen), 32'(doneExp));
    checkOutput({tag, "_err"}, 32'(frameErr), 32'(modelErr));
    checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_valid", 32'(pixValid), 32'd0);
    checkOutput("rst_data", {16'h0, pixData}, 32'd0);
    checkOutput("rst_x", 32'(pixX), 32'd0);
    checkOutput("rst_y", 32'(pixY), 32'd0);
    checkOutput("rst_fs", 32'(frameStart), 32'd0);
    checkOutput("rst_done", 32'(frameDone), 32'd0);
    checkOutput("rst_err", 32'(frameErr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    armed = cfgDone; inFrame = 1'b0; modelErr = 1'b0; clearPending = 1'b0;
    expQ.delete();
  endtask

  initial begin
    checks = 0; errors = 0; doneExp = 0; doneSeen = 0; pixSeen = 0;
    armed = 1'b0; inFrame = 1'b0; modelErr = 1'b0; clearPending = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("init_valid", 32'(pixValid), 32'd0);
    checkOutput("init_err", 32'(frameErr), 32'd0);
    checkOutput("init_done", 32'(frameDone), 32'd0);
    rst = 1'b1;
    cfgDone = 1'b1; armed = 1'b1;
    repeat (2) @(negedge clk);

    // 4x2 frame with 0x12,0x34,... bytes
    sendVsync();
    sendLine(8, 1'b1);
    sendLine(8, 1'b1);
    sendVsync();
    checkpoint("frame1");
    checkOutput("f1_count", 32'(pixSeen), 32'(EXP_CNT));
    checkOutput("f1_first_data", {16'h0, firstData}, 32'h1234);
    checkOutput("f1_first_x", 32'(firstX), 32'd0);
    checkOutput("f1_first_y", 32'(firstY), 32'd0);
    checkOutput("f1_first_fs", 32'(firstFs), 32'd1);
    checkOutput("f1_last_x", 32'(lastX), 32'(EXP_LASTX));
    checkOutput("f1_last_y", 32'(lastY), 32'(EXP_LASTY));
    checkOutput("f1_done_lit", 32'(doneSeen), 32'd1);
    checkOutput("f1_err_lit", 32'(frameErr), 32'd0);

    // Restart mid-frame: lines without a vsync must be ignored
    dropCfg();
    sendLine(8, 1'b0);
    sendLine(8, 1'b0);
    checkpoint("midstart");
    sendVsync();
    sendLine(8, 1'b0);
    sendLine(8, 1'b0);
    sendVsync();
    checkpoint("frame2");

    // Odd byte count on first line
    sendLine(7, 1'b0);
    sendLine(8, 1'b0);
    sendVsync();
    checkpoint("oddline");
    checkOutput("odd_err_lit", 32'(frameErr), 32'd1);

    // Three lines against V_ACTIVE=2
    dropCfg();
    sendVsync();
    checkOutput("err_cleared", 32'(frameErr), 32'd0);
    sendLine(8, 1'b0);
    sendLine(8, 1'b0);
    sendLine(8, 1'b0);
    sendVsync();
    checkpoint("overflow");
    checkOutput("ovf_err_lit", 32'(frameErr), 32'd1);

    // Reset mid-line, then a clean frame
    sendLine(8, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hA5);
    doReset();
    sendVsync();
    sendLine(8, 1'b0);
    sendLine(8, 1'b0);
    sendVsync();
    checkpoint("postreset");
    checkOutput("pr_err_lit", 32'(frameErr), 32'd0);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        sendLine(($urandom % 4 == 0) ? int'($urandom_range(5, 9)) : 8, 1'b0);
      end
      sendVsync();
      checkpoint("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
